// File: rtl/channel_to_pulse.sv
// Receiving end of a valid/accept channel: registers each accepted word, strobes a pulse,
// counts accepts, and enforces a minimum spacing of G cycles between consecutive accepts.
module channel_to_pulse #(
    parameter int unsigned N = 1,
    parameter int unsigned G = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] i_in_d,
    input  logic         i_in_v,
    output logic         o_in_a,
    input  logic         i_hold,
    output logic [N-1:0] o_data_out,
    output logic         o_pulse,
    output logic [15:0]  o_accepted
);

    localparam int unsigned CW = $clog2(G) + 1;
    localparam bit HasHoldoff = (G > 1);

    typedef enum logic {StIdle, StHoldoff} state_e;

    state_e          r_state;
    state_e          w_state_next;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_next;
    logic            w_accept;
    logic [N-1:0]    r_data;
    logic            r_pulse;
    logic [15:0]     r_accepted;

    assign o_in_a     = i_in_v & ~i_hold & (r_state == StIdle);
    assign w_accept   = i_in_v & o_in_a;
    assign o_data_out = r_data;
    assign o_pulse    = r_pulse;
    assign o_accepted = r_accepted;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        unique case (r_state)
            StIdle: begin
                if (w_accept && HasHoldoff) begin
                    w_state_next = StHoldoff;
                    w_cnt_next   = CW'(G - 1);
                end
            end
            StHoldoff: begin
                // Countdown runs regardless of hold; leaving at 1 gives an accept at t+G.
                w_cnt_next = r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_data     <= '0;
            r_pulse    <= 1'b0;
            r_accepted <= 16'h0000;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_pulse <= w_accept;
            if (w_accept) begin
                r_data     <= i_in_d;
                r_accepted <= r_accepted + 16'h0001;
            end
        end
    end

endmodule

// File: tb/tb_channel_to_pulse.sv
// Directed bench for channel_to_pulse: table of per-cycle vectors over G=1, G=4 and G=8
// instances, plus a long counter-wrap sequence.
module tb_channel_to_pulse;

    logic        clk;
    logic        reset;
    logic [7:0]  r_d;
    logic        r_v;
    logic        r_hold;

    logic        w_a1, w_a4, w_a8;
    logic [7:0]  w_do1, w_do4, w_do8;
    logic        w_p1, w_p4, w_p8;
    logic [15:0] w_acc1, w_acc4, w_acc8;

    logic [1:0]  r_sel;
    logic        w_a;
    logic [7:0]  w_do;
    logic        w_p;
    logic [15:0] w_acc;

    int unsigned n_checks;
    int unsigned n_errors;

    channel_to_pulse #(.N(8), .G(1)) u_g1 (
        .clk(clk), .reset(reset), .i_in_d(r_d), .i_in_v(r_v), .o_in_a(w_a1),
        .i_hold(r_hold), .o_data_out(w_do1), .o_pulse(w_p1), .o_accepted(w_acc1)
    );
    channel_to_pulse #(.N(8), .G(4)) u_g4 (
        .clk(clk), .reset(reset), .i_in_d(r_d), .i_in_v(r_v), .o_in_a(w_a4),
        .i_hold(r_hold), .o_data_out(w_do4), .o_pulse(w_p4), .o_accepted(w_acc4)
    );
    channel_to_pulse #(.N(8), .G(8)) u_g8 (
        .clk(clk), .reset(reset), .i_in_d(r_d), .i_in_v(r_v), .o_in_a(w_a8),
        .i_hold(r_hold), .o_data_out(w_do8), .o_pulse(w_p8), .o_accepted(w_acc8)
    );

    always_comb begin
        w_a   = w_a1;
        w_do  = w_do1;
        w_p   = w_p1;
        w_acc = w_acc1;
        case (r_sel)
            2'd1: begin w_a = w_a4; w_do = w_do4; w_p = w_p4; w_acc = w_acc4; end
            2'd2: begin w_a = w_a8; w_do = w_do8; w_p = w_p8; w_acc = w_acc8; end
            default: ;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  sel;
        logic        rst;
        logic        v;
        logic        hold;
        logic [7:0]  d;
        logic        exp_a;
        logic [7:0]  exp_do;
        logic        exp_p;
        logic [15:0] exp_acc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [1:0] sel, input logic rst, input logic v, input logic hold,
                       input logic [7:0] d, input logic ea, input logic [7:0] edo,
                       input logic ep, input logic [15:0] eacc);
        vec_t t;
        t.sel = sel; t.rst = rst; t.v = v; t.hold = hold; t.d = d;
        t.exp_a = ea; t.exp_do = edo; t.exp_p = ep; t.exp_acc = eacc;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        r_v      = 1'b0;
        r_hold   = 1'b0;
        r_d      = 8'h00;
        r_sel    = 2'd0;

        // G=1 streaming: four back-to-back accepts
        add(0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0);
        add(0, 0, 1, 0, 8'h11, 1, 8'h00, 0, 0);
        add(0, 0, 1, 0, 8'h22, 1, 8'h11, 1, 1);
        add(0, 0, 1, 0, 8'h33, 1, 8'h22, 1, 2);
        add(0, 0, 1, 0, 8'h44, 1, 8'h33, 1, 3);
        add(0, 0, 0, 0, 8'h99, 0, 8'h44, 1, 4);
        add(0, 0, 0, 0, 8'h99, 0, 8'h44, 0, 4);
        // G=1 hold for three cycles
        add(0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0);
        add(0, 0, 1, 1, 8'h55, 0, 8'h00, 0, 0);
        add(0, 0, 1, 1, 8'h55, 0, 8'h00, 0, 0);
        add(0, 0, 1, 1, 8'h55, 0, 8'h00, 0, 0);
        add(0, 0, 1, 0, 8'h55, 1, 8'h00, 0, 0);
        add(0, 0, 0, 0, 8'h00, 0, 8'h55, 1, 1);
        add(0, 0, 0, 0, 8'h00, 0, 8'h55, 0, 1);
        // G=4 with valid held: accepts at 0, 4, 8
        add(1, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0);
        add(1, 0, 1, 0, 8'hA5, 1, 8'h00, 0, 0);
        add(1, 0, 1, 0, 8'hA5, 0, 8'hA5, 1, 1);
        add(1, 0, 1, 0, 8'hA5, 0, 8'hA5, 0, 1);
        add(1, 0, 1, 0, 8'hA5, 0, 8'hA5, 0, 1);
        add(1, 0, 1, 0, 8'hA5, 1, 8'hA5, 0, 1);
        add(1, 0, 1, 0, 8'hA5, 0, 8'hA5, 1, 2);
        add(1, 0, 1, 0, 8'hA5, 0, 8'hA5, 0, 2);
        add(1, 0, 1, 0, 8'hA5, 0, 8'hA5, 0, 2);
        add(1, 0, 1, 0, 8'hA5, 1, 8'hA5, 0, 2);
        add(1, 0, 0, 0, 8'hA5, 0, 8'hA5, 1, 3);
        add(1, 0, 0, 0, 8'hA5, 0, 8'hA5, 0, 3);
        // G=4, hold across the end of holdoff; valid drops mid-holdoff
        add(1, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0);
        add(1, 0, 1, 0, 8'h3C, 1, 8'h00, 0, 0);
        add(1, 0, 1, 1, 8'h3C, 0, 8'h3C, 1, 1);
        add(1, 0, 0, 1, 8'hEE, 0, 8'h3C, 0, 1);
        add(1, 0, 1, 1, 8'h3C, 0, 8'h3C, 0, 1);
        add(1, 0, 1, 1, 8'h3C, 0, 8'h3C, 0, 1);
        add(1, 0, 1, 1, 8'h3C, 0, 8'h3C, 0, 1);
        add(1, 0, 1, 0, 8'h7E, 1, 8'h3C, 0, 1);
        add(1, 0, 0, 0, 8'hFF, 0, 8'h7E, 1, 2);
        add(1, 0, 0, 0, 8'hFF, 0, 8'h7E, 0, 2);
        // G=8, reset mid-holdoff aborts the countdown
        add(2, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0);
        add(2, 0, 1, 0, 8'h99, 1, 8'h00, 0, 0);
        add(2, 0, 1, 0, 8'h99, 0, 8'h99, 1, 1);
        add(2, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0);
        add(2, 0, 1, 0, 8'h66, 1, 8'h00, 0, 0);
        add(2, 0, 0, 0, 8'h00, 0, 8'h66, 1, 1);

        @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            r_sel  = vecs[i].sel;
            reset  = vecs[i].rst;
            r_v    = vecs[i].rst ? 1'b0 : vecs[i].v;
            r_hold = vecs[i].rst ? 1'b0 : vecs[i].hold;
            r_d    = vecs[i].rst ? 8'h00 : vecs[i].d;
            #4;
            check($sformatf("v%0d in_a", i), {15'h0, w_a}, {15'h0, vecs[i].exp_a});
            check($sformatf("v%0d data_out", i), {8'h0, w_do}, {8'h0, vecs[i].exp_do});
            check($sformatf("v%0d pulse", i), {15'h0, w_p}, {15'h0, vecs[i].exp_p});
            check($sformatf("v%0d accepted", i), w_acc, vecs[i].exp_acc);
            @(posedge clk);
            #1;
        end

        // Counter wrap on the G=1 instance
        r_sel  = 2'd0;
        reset  = 1'b1;
        r_v    = 1'b0;
        r_hold = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        r_v   = 1'b1;
        for (int i = 0; i < 65534; i++) begin
            r_d = i[7:0];
            @(posedge clk);
            #1;
        end
        r_v = 1'b0;
        #4;
        check("wrap pre", w_acc, 16'hFFFE);
        check("wrap data", {8'h0, w_do}, {8'h0, 8'hFD});
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            r_v = 1'b1;
            r_d = 8'hC0 + 8'(k);
            @(posedge clk);
            #1;
            r_v = 1'b0;
            #4;
            check($sformatf("wrap step%0d", k), w_acc, 16'hFFFF + 16'(k));
            check($sformatf("wrap pulse%0d", k), {15'h0, w_p}, 16'h0001);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/channel_to_pulse.md
CHANNEL_TO_PULSE -- requirements
Module: channel_to_pulse

Interface
- REQ-001: Parameter N, default 1, data width of the input Channel and the data_out register.
- REQ-002: Parameter G, default 1, minimum spacing in clk cycles between consecutive accepts; legal range G >= 1.
- REQ-003: Port clk, input, 1, rising-edge clock for all state.
- REQ-004: Port reset, input, 1, reset, asynchronous, active-high.
- REQ-005: Port in, Channel (d: N in, v: 1 in, a: 1 out), the word source; the block is the receiving end.
- REQ-006: Port hold, input, 1, blocks acceptance while high.
- REQ-007: Port data_out, output, N, the last accepted word, registered.
- REQ-008: Port pulse, output, 1, one-cycle strobe marking that data_out was updated.
- REQ-009: Port accepted, output, 16, count of accepted words, wraps modulo 2^16.

Function
- REQ-010: The block SHALL have two states, IDLE and HOLDOFF, plus a holdoff counter of width $clog2(G)+1.
- REQ-011: in.a SHALL be combinational and equal to in.v & ~hold & (state == IDLE).
- REQ-012: A handshake (accept) SHALL occur in any cycle where in.v = 1 and in.a = 1; in.d SHALL be sampled only in that cycle.
- REQ-013: On accept in cycle t, data_out SHALL take in.d at the closing edge of t and be visible from cycle t+1.
- REQ-014: On accept in cycle t, pulse SHALL be 1 in cycle t+1 only, unless another accept occurs in cycle t+1 (possible only when G = 1), in which case pulse SHALL stay 1 for t+2 as well.
- REQ-015: data_out SHALL hold its value in all cycles with no accept.
- REQ-016: Each accept SHALL increment accepted by 1 at the same edge as the data_out update; 0xFFFF SHALL wrap to 0x0000.
- REQ-017: With G = 1, the block SHALL never enter HOLDOFF and SHALL accept one word per cycle when in.v = 1 and hold = 0.
- REQ-018: With G > 1, an accept in IDLE SHALL move to HOLDOFF and load the counter with G-1.
- REQ-019: In HOLDOFF, the counter SHALL decrement by 1 each cycle; when it equals 1, the next state SHALL be IDLE.
- REQ-020: The earliest next accept after an accept in cycle t SHALL be cycle t+G.
- REQ-021: hold SHALL NOT affect the HOLDOFF countdown.
- REQ-022: hold asserted in IDLE SHALL keep in.a = 0 and the state in IDLE indefinitely.
- REQ-023: in.v deasserting while in HOLDOFF or under hold SHALL have no effect; the block SHALL NOT depend on in.d when in.v = 0.
- REQ-024: The block SHALL never assert in.a while in.v = 0.

Reset
- REQ-025: While reset = 1: state = IDLE, counter = 0, data_out = 0, pulse = 0, accepted = 0.
- REQ-026: Reset asserted mid-HOLDOFF SHALL abort the countdown; the first cycle after reset deasserts SHALL allow an accept.
- REQ-027: While reset = 1, in.a SHALL be 0 only through state dependence, i.e. it equals in.v & ~hold (state = IDLE); the bench SHALL NOT drive in.v during reset.

Verification
- REQ-028: N=8, G=1, in.v=1 for cycles 0..3 with d = 0x11,0x22,0x33,0x44, hold=0 -> in.a=1 in cycles 0..3, data_out=0x11..0x44 in cycles 1..4, pulse=1 in cycles 1..4, accepted=4.
- REQ-029: N=8, G=4, in.v held 1, d=0xA5 -> accepts at cycles 0,4,8; in.a=0 in cycles 1-3 and 5-7; pulse=1 only in cycles 1,5,9.
- REQ-030: G=1, in.v=1, hold=1 for cycles 0..2, then 0 -> in.a=0 in cycles 0..2, first accept in cycle 3, pulse in cycle 4, data_out unchanged before cycle 4.
- REQ-031: G=4, accept in cycle 0, hold=1 in cycles 1..5 -> state IDLE from cycle 4; no accept until cycle 6 when hold=0; pulse in cycle 7.
- REQ-032: accepted preloaded to 0xFFFE by 65534 accepts, then 3 more accepts -> accepted = 0xFFFF, 0x0000, 0x0001.
- REQ-033: G=8, accept in cycle 0, reset pulsed in cycle 2 -> all outputs 0 during reset; accept allowed in the first cycle after reset deasserts.
